// File: rtl/regs_memwb.sv
// regs_memwb: MEM/WB pipeline register with stall/flush, load alignment/extension and write-back data select
module regs_memwb #(
    parameter int DATA_W = 32,
    parameter int MUL_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_o_dm2rf,
    input  logic              mem_o_hilowe,
    input  logic              mem_o_rfwe,
    input  logic [3:0]        mem_o_bytesel,
    input  logic              mem_o_loadsign,
    input  logic [4:0]        mem_o_rfwa,
    input  logic [MUL_W-1:0]  mem_o_mulres,
    input  logic [DATA_W-1:0] mem_o_alures,
    input  logic [DATA_W-1:0] mem_o_dmdout,
    output logic              wb_o_valid,
    output logic              wb_o_rfwe,
    output logic [4:0]        wb_o_rfwa,
    output logic [DATA_W-1:0] wb_o_rfwd,
    output logic              wb_o_hilowe,
    output logic [DATA_W-1:0] wb_o_hi,
    output logic [DATA_W-1:0] wb_o_lo,
    output logic              wb_o_misalign
);
    logic              r_valid;
    logic              r_dm2rf;
    logic              r_hilowe;
    logic              r_rfwe;
    logic [3:0]        r_bytesel;
    logic              r_loadsign;
    logic [4:0]        r_rfwa;
    logic [MUL_W-1:0]  r_mulres;
    logic [DATA_W-1:0] r_alures;
    logic [DATA_W-1:0] r_dmdout;

    logic [1:0]        w_off;
    logic              w_is_half;
    logic              w_is_byte;
    logic              w_is_word;
    logic [15:0]       w_half;
    logic [7:0]        w_byte;
    logic [DATA_W-1:0] w_load;
    logic              w_misalign;

    // Capture the MEM stage each cycle; flush turns the entry into a bubble, stall holds it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_dm2rf    <= 1'b0;
            r_hilowe   <= 1'b0;
            r_rfwe     <= 1'b0;
            r_bytesel  <= '0;
            r_loadsign <= 1'b0;
            r_rfwa     <= '0;
            r_mulres   <= '0;
            r_alures   <= '0;
            r_dmdout   <= '0;
        end else if (flush) begin
            r_valid  <= 1'b0;
            r_dm2rf  <= 1'b0;
            r_hilowe <= 1'b0;
            r_rfwe   <= 1'b0;
        end else if (!stall) begin
            r_valid    <= 1'b1;
            r_dm2rf    <= mem_o_dm2rf;
            r_hilowe   <= mem_o_hilowe;
            r_rfwe     <= mem_o_rfwe;
            r_bytesel  <= mem_o_bytesel;
            r_loadsign <= mem_o_loadsign;
            r_rfwa     <= mem_o_rfwa;
            r_mulres   <= mem_o_mulres;
            r_alures   <= mem_o_alures;
            r_dmdout   <= mem_o_dmdout;
        end
    end

    // Select the addressed sub-word, extend it, and flag loads not aligned to their width
    always_comb begin
        w_off      = r_alures[1:0];
        w_is_half  = r_bytesel == 4'b0011;
        w_is_byte  = r_bytesel == 4'b0001;
        w_is_word  = !w_is_half && !w_is_byte;
        w_half     = w_off[1] ? r_dmdout[31:16] : r_dmdout[15:0];
        w_byte     = w_off == 2'd0 ? r_dmdout[7:0]   :
                     w_off == 2'd1 ? r_dmdout[15:8]  :
                     w_off == 2'd2 ? r_dmdout[23:16] : r_dmdout[31:24];
        w_load     = w_is_half ? {{(DATA_W-16){r_loadsign & w_half[15]}}, w_half} :
                     w_is_byte ? {{(DATA_W-8){r_loadsign & w_byte[7]}}, w_byte}  : r_dmdout;
        w_misalign = r_dm2rf & ((w_is_word & (w_off != 2'd0)) | (w_is_half & w_off[0]));
    end

    assign wb_o_valid    = r_valid;
    assign wb_o_misalign = w_misalign;
    assign wb_o_rfwd     = r_dm2rf ? w_load : r_alures;
    assign wb_o_rfwe     = r_valid & r_rfwe & (r_rfwa != 5'd0) & ~w_misalign;
    assign wb_o_rfwa     = r_rfwa;
    assign wb_o_hilowe   = r_valid & r_hilowe;
    assign wb_o_hi       = r_mulres[MUL_W-1 -: DATA_W];
    assign wb_o_lo       = r_mulres[DATA_W-1:0];
endmodule
